// File: rtl/subleq_seq_pkg.sv
// Shared definitions for the SUBLEQ instruction sequencer: default widths,
// the halt address and the 3-bit sequencer state encoding.
package subleq_seq_pkg;

  // Default address / PC width; must agree with pc_reg.
  localparam int AW_DEF = 8;

  // Default data word width (two's-complement signed).
  localparam int DW_DEF = 8;

  // A PC equal to this address means "halt".
  localparam int HLT_ADDR = 0;

  // One state per cycle; S_FA..S_WB make up one 7-cycle instruction.
  typedef enum logic [2:0] {
    S_FA   = 3'd0,  // present PC (word A address)
    S_FB   = 3'd1,  // capture A, present PC+1
    S_FC   = 3'd2,  // capture B, present PC+2
    S_RA   = 3'd3,  // capture C, present A
    S_RB   = 3'd4,  // capture mem[A], present B
    S_EX   = 3'd5,  // capture mem[B], present B
    S_WB   = 3'd6,  // write result, update PC
    S_HALT = 3'd7   // parked until reset
  } state_e;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: res = b - a (wrapping, overflow ignored) and the
// "less than or equal to zero" branch flag taken on the signed result.
module subleq_alu
  import subleq_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          leq
);

  logic [DW-1:0] diff_s;

  // Wrapping subtract and sign/zero test of the result
  always_comb begin
    diff_s = b - a;
    res    = diff_s;
    leq    = diff_s[DW-1] | (diff_s == {DW{1'b0}});
  end

endmodule

// File: rtl/subleq_seq.sv
// SUBLEQ-OISC instruction sequencer. Fetches A,B,C at PC from a unified
// memory with one-cycle read latency, reads mem[A] and mem[B], writes
// mem[B]-mem[A] back to B, and hands pc_reg either C (result <= 0) or PC+3.
// PC == 0 parks the sequencer in S_HALT until RST.
module subleq_seq
  import subleq_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [AW-1:0] PC,
  output logic [AW-1:0] PCnew,
  output logic          WE,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WE,
  output logic          HALTED
);

  state_e        state_r;
  state_e        state_nx_s;

  logic [AW-1:0] op_a_r;
  logic [AW-1:0] op_b_r;
  logic [AW-1:0] op_c_r;
  logic [DW-1:0] val_a_r;
  logic [DW-1:0] val_b_r;

  // Read-data buffer used across a stall. While EN is low the address bus
  // keeps showing the current state's decode, so after the first stalled
  // cycle the memory returns data for the wrong address. The word that was
  // actually requested is captured on the first stalled cycle and replayed
  // when EN returns.
  logic          stall_r;
  logic [DW-1:0] hold_r;
  logic [DW-1:0] rdata_s;

  logic [DW-1:0] res_s;
  logic          leq_s;

  logic [AW-1:0] pc_p1_s;
  logic [AW-1:0] pc_p2_s;
  logic [AW-1:0] pc_p3_s;
  logic          pc_halt_s;

  // Sequential PC offsets wrap modulo 2^AW
  always_comb begin
    pc_p1_s   = PC + AW'(1);
    pc_p2_s   = PC + AW'(2);
    pc_p3_s   = PC + AW'(3);
    pc_halt_s = (PC == AW'(HLT_ADDR));
  end

  // Select live memory data or the word held over a stall
  always_comb begin
    if (stall_r) begin
      rdata_s = hold_r;
    end else begin
      rdata_s = MEM_RDATA;
    end
  end

  subleq_alu #(
    .DW (DW)
  ) u_alu (
    .a   (val_a_r),
    .b   (val_b_r),
    .res (res_s),
    .leq (leq_s)
  );

  // State register: advances only when enabled
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_FA;
    end else if (EN) begin
      state_r <= state_nx_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state decode: linear walk through the instruction, halt on PC==0
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_FA: begin
        if (pc_halt_s) begin
          state_nx_s = S_HALT;
        end else begin
          state_nx_s = S_FB;
        end
      end
      S_FB:    state_nx_s = S_FC;
      S_FC:    state_nx_s = S_RA;
      S_RA:    state_nx_s = S_RB;
      S_RB:    state_nx_s = S_EX;
      S_EX:    state_nx_s = S_WB;
      S_WB:    state_nx_s = S_FA;
      S_HALT:  state_nx_s = S_HALT;
      default: state_nx_s = S_FA;
    endcase
  end

  // Operand capture: each state latches the word requested one cycle earlier
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a_r  <= {AW{1'b0}};
      op_b_r  <= {AW{1'b0}};
      op_c_r  <= {AW{1'b0}};
      val_a_r <= {DW{1'b0}};
      val_b_r <= {DW{1'b0}};
    end else if (EN) begin
      case (state_r)
        S_FB:    op_a_r  <= AW'(rdata_s);
        S_FC:    op_b_r  <= AW'(rdata_s);
        S_RA:    op_c_r  <= AW'(rdata_s);
        S_RB:    val_a_r <= rdata_s;
        S_EX:    val_b_r <= rdata_s;
        default: begin
          op_a_r  <= op_a_r;
          op_b_r  <= op_b_r;
          op_c_r  <= op_c_r;
          val_a_r <= val_a_r;
          val_b_r <= val_b_r;
        end
      endcase
    end else begin
      op_a_r  <= op_a_r;
      op_b_r  <= op_b_r;
      op_c_r  <= op_c_r;
      val_a_r <= val_a_r;
      val_b_r <= val_b_r;
    end
  end

  // Stall buffer: grab the in-flight read word on the first stalled cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_r <= 1'b0;
      hold_r  <= {DW{1'b0}};
    end else if (!EN) begin
      stall_r <= 1'b1;
      if (!stall_r) begin
        hold_r <= MEM_RDATA;
      end else begin
        hold_r <= hold_r;
      end
    end else begin
      stall_r <= 1'b0;
      hold_r  <= hold_r;
    end
  end

  // Moore output decode; everything is forced quiet while RST is high so no
  // write can coincide with pc_reg's own reset
  always_comb begin
    PCnew     = {AW{1'b0}};
    WE        = 1'b0;
    MEM_ADDR  = {AW{1'b0}};
    MEM_WDATA = {DW{1'b0}};
    MEM_WE    = 1'b0;
    HALTED    = 1'b0;
    if (RST) begin
      PCnew = {AW{1'b0}};
    end else begin
      case (state_r)
        S_FA: begin
          if (pc_halt_s) begin
            MEM_ADDR = {AW{1'b0}};
          end else begin
            MEM_ADDR = PC;
          end
        end
        S_FB: MEM_ADDR = pc_p1_s;
        S_FC: MEM_ADDR = pc_p2_s;
        S_RA: MEM_ADDR = op_a_r;
        S_RB: MEM_ADDR = op_b_r;
        S_EX: MEM_ADDR = op_b_r;
        S_WB: begin
          MEM_ADDR  = op_b_r;
          MEM_WDATA = res_s;
          MEM_WE    = EN;
          WE        = EN;
          if (leq_s) begin
            PCnew = op_c_r;
          end else begin
            PCnew = pc_p3_s;
          end
        end
        S_HALT:  HALTED = 1'b1;
        default: HALTED = 1'b0;
      endcase
    end
  end

endmodule
